cache_refill_ctrl: RTL and testbench

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

---
 rtl/cache_pkg.sv | 25 ++
 rtl/cache_victim_rr.sv | 33 +++
 rtl/cache_refill_ctrl.sv | 162 ++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill controller: FSM encoding and tag-word layout.
// Imported by the refill controller and its round-robin victim selector.
package cache_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_LOOKUP = 3'd1;
   localparam state_t ST_FILL   = 3'd2;
   localparam state_t ST_TAGWR  = 3'd3;
   localparam state_t ST_RESP   = 3'd4;

   localparam int TAG_WORD_W = 32;
   localparam int VALID_BIT  = 31;

   // Tag SRAM word: valid flag on top, tag right-justified in the low bits.
   function automatic logic [TAG_WORD_W-1:0] make_tag_word(input logic [VALID_BIT-1:0] tag);
      logic [TAG_WORD_W-1:0] word;
      word            = '0;
      word[VALID_BIT] = 1'b1;
      word[VALID_BIT-1:0] = tag;
      return word;
   endfunction

endpackage

// File: rtl/cache_victim_rr.sv
// Round-robin victim way selector: one-hot pointer output that advances once per
// completed refill and wraps modulo NUM_WAYS.
module cache_victim_rr
   import cache_pkg::*;
#(
   parameter int NUM_WAYS = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                advance_i,
   output logic [NUM_WAYS-1:0] victim_o
);

   localparam int PTR_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam logic [PTR_W-1:0] LAST_WAY = PTR_W'(NUM_WAYS - 1);

   logic [PTR_W-1:0] rr_ptr;

   // With a single way LAST_WAY is zero, so the pointer never leaves way 0.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr <= '0;
      end else if (advance_i) begin
         rr_ptr <= (rr_ptr == LAST_WAY) ? '0 : rr_ptr + PTR_W'(1);
      end
   end

   always_comb begin
      victim_o         = '0;
      victim_o[rr_ptr] = 1'b1;
   end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Blocking read-miss refill controller: looks up one CPU read at a time, refills a
// whole line beat by beat on a miss, writes the tag last and replays the lookup.
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int NUM_WAYS         = 2,
   parameter int ADDR_WIDTH       = 32,
   parameter int DATA_WIDTH       = 32,
   parameter int CLINE_SIZE_WORD  = 4,
   parameter int CLINE_ADDR_WIDTH = 7,
   localparam int OFF_W           = $clog2(CLINE_SIZE_WORD),
   localparam int TAG_OFFSET      = OFF_W + CLINE_ADDR_WIDTH,
   localparam int TAG_WIDTH       = ADDR_WIDTH - TAG_OFFSET
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  logic [ADDR_WIDTH-1:0]       req_addr_i,
   output logic                        resp_valid_o,
   output logic [DATA_WIDTH-1:0]       resp_data_o,
   output logic [CLINE_ADDR_WIDTH-1:0] sram_index_o,
   output logic [OFF_W-1:0]            sram_word_o,
   output logic                        sram_re_o,
   output logic [ADDR_WIDTH-1:0]       lookup_addr_o,
   input  logic                        hit_i,
   input  logic [DATA_WIDTH-1:0]       hit_data_i,
   output logic [NUM_WAYS-1:0]         tag_we_o,
   output logic [TAG_WORD_W-1:0]       tag_wdata_o,
   output logic [NUM_WAYS-1:0]         data_we_o,
   output logic [DATA_WIDTH-1:0]       data_wdata_o,
   output logic                        mem_req_o,
   output logic [ADDR_WIDTH-1:0]       mem_addr_o,
   input  logic                        mem_ack_i,
   input  logic [DATA_WIDTH-1:0]       mem_data_i
);

   // One extra bit so the counter can reach CLINE_SIZE_WORD after the last beat.
   localparam int BEAT_W = OFF_W + 1;
   localparam logic [BEAT_W-1:0] LINE_BEATS = BEAT_W'(CLINE_SIZE_WORD);

   state_t state_q;
   state_t state_d;

   logic [ADDR_WIDTH-1:0]       addr_q;
   logic [DATA_WIDTH-1:0]       rdata_q;
   logic [BEAT_W-1:0]           beat_q;
   logic                        gap_q;
   logic [NUM_WAYS-1:0]         victim_q;
   logic [NUM_WAYS-1:0]         rr_victim;

   logic [TAG_WIDTH-1:0]        addr_tag;
   logic [CLINE_ADDR_WIDTH-1:0] addr_index;
   logic [OFF_W-1:0]            addr_word;
   logic [CLINE_ADDR_WIDTH-1:0] req_index;
   logic [OFF_W-1:0]            req_word;

   logic accept;
   logic beat_ack;
   logic fill_done;
   logic rr_advance;

   assign addr_tag   = addr_q[ADDR_WIDTH-1:TAG_OFFSET];
   assign addr_index = addr_q[TAG_OFFSET-1:OFF_W];
   assign addr_word  = addr_q[OFF_W-1:0];
   assign req_index  = req_addr_i[TAG_OFFSET-1:OFF_W];
   assign req_word   = req_addr_i[OFF_W-1:0];

   assign accept     = (state_q == ST_IDLE) && req_valid_i;
   // Every beat is followed by one idle cycle (gap_q), including the last one,
   // so an ack can only land while the request is actually up.
   assign mem_req_o  = (state_q == ST_FILL) && !gap_q;
   assign beat_ack   = mem_req_o && mem_ack_i;
   assign fill_done  = (state_q == ST_FILL) && gap_q && (beat_q == LINE_BEATS);
   assign rr_advance = (state_q == ST_TAGWR);

   cache_victim_rr #(
      .NUM_WAYS (NUM_WAYS)
   ) u_victim (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .advance_i (rr_advance),
      .victim_o  (rr_victim)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (req_valid_i) state_d = ST_LOOKUP;
         ST_LOOKUP: state_d = hit_i ? ST_RESP : ST_FILL;
         ST_FILL:   if (fill_done) state_d = ST_TAGWR;
         ST_TAGWR:  state_d = ST_LOOKUP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // A reset mid-fill simply drops back to IDLE; the tag is only written in
   // TAGWR, so a partially refilled line never becomes valid.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         beat_q   <= '0;
         gap_q    <= 1'b0;
         victim_q <= '0;
         rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_LOOKUP: begin
               if (hit_i) begin
                  rdata_q <= hit_data_i;
               end else begin
                  victim_q <= rr_victim;
                  beat_q   <= '0;
                  gap_q    <= 1'b0;
               end
            end
            ST_FILL: begin
               if (beat_ack) begin
                  beat_q <= beat_q + BEAT_W'(1);
                  gap_q  <= 1'b1;
               end else if (gap_q) begin
                  gap_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         addr_q <= req_addr_i;
      end
   end

   always_comb begin
      req_ready_o   = (state_q == ST_IDLE);
      resp_valid_o  = (state_q == ST_RESP);
      resp_data_o   = rdata_q;
      lookup_addr_o = addr_q;

      // The replay in TAGWR re-reads the originally requested word.
      sram_re_o     = accept || (state_q == ST_TAGWR);
      sram_index_o  = addr_index;
      sram_word_o   = addr_word;
      if (state_q == ST_IDLE) begin
         sram_index_o = req_index;
         sram_word_o  = req_word;
      end else if (state_q == ST_FILL) begin
         sram_word_o  = beat_q[OFF_W-1:0];
      end

      tag_we_o     = (state_q == ST_TAGWR) ? victim_q : '0;
      tag_wdata_o  = make_tag_word(VALID_BIT'(addr_tag));
      data_we_o    = beat_ack ? victim_q : '0;
      data_wdata_o = mem_data_i;
      mem_addr_o   = {addr_tag, addr_index, beat_q[OFF_W-1:0]};
   end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Testbench for cache_refill_ctrl: behavioural tag/data SRAMs and a memory responder
// around the DUT, with a line-level cache model predicting hits, victims and latency.
module tb_cache_refill_ctrl;

   localparam int NW  = 2;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int CLS = 4;
   localparam int IW  = 7;
   localparam int NIDX = 1 << IW;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic [AW-1:0] req_addr_i = '0;
   logic          resp_valid_o;
   logic [DW-1:0] resp_data_o;
   logic [IW-1:0] sram_index_o;
   logic [1:0]    sram_word_o;
   logic          sram_re_o;
   logic [AW-1:0] lookup_addr_o;
   logic          hit_i;
   logic [DW-1:0] hit_data_i;
   logic [NW-1:0] tag_we_o;
   logic [31:0]   tag_wdata_o;
   logic [NW-1:0] data_we_o;
   logic [DW-1:0] data_wdata_o;
   logic          mem_req_o;
   logic [AW-1:0] mem_addr_o;
   logic          mem_ack_i = 1'b0;
   logic [DW-1:0] mem_data_i = '0;

   cache_refill_ctrl #(
      .NUM_WAYS(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .CLINE_SIZE_WORD(CLS), .CLINE_ADDR_WIDTH(IW)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
      .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
      .sram_index_o(sram_index_o), .sram_word_o(sram_word_o), .sram_re_o(sram_re_o),
      .lookup_addr_o(lookup_addr_o), .hit_i(hit_i), .hit_data_i(hit_data_i),
      .tag_we_o(tag_we_o), .tag_wdata_o(tag_wdata_o),
      .data_we_o(data_we_o), .data_wdata_o(data_wdata_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Backing memory contents; word 0x40 carries the preloaded hit pattern.
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      if (a == 32'h40) return 32'hDEAD_BEEF;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   // Environment: tag/data SRAM arrays written by the DUT's strobes.
   logic        e_tv  [NW][NIDX];
   logic [22:0] e_tag [NW][NIDX];
   logic [31:0] e_dat [NW][NIDX][CLS];
   logic        env_clr = 1'b0;
   logic        pl_en   = 1'b0;

   logic [IW-1:0] l_idx;
   logic [22:0]   l_tag;
   logic [1:0]    l_word;
   assign l_idx  = lookup_addr_o[8:2];
   assign l_tag  = lookup_addr_o[31:9];
   assign l_word = lookup_addr_o[1:0];

   always_comb begin
      hit_i      = 1'b0;
      hit_data_i = '0;
      for (int w = 0; w < NW; w++) begin
         if (e_tv[w][l_idx] && e_tag[w][l_idx] == l_tag) begin
            hit_i      = 1'b1;
            hit_data_i = e_dat[w][l_idx][l_word];
         end
      end
   end

   int          tag_cnt = 0;
   int          last_tag_way = -1;
   logic [31:0] last_tag_word = '0;
   int          proto_err = 0;

   always @(posedge clk) begin
      if (env_clr) begin
         for (int w = 0; w < NW; w++)
            for (int i = 0; i < NIDX; i++) e_tv[w][i] <= 1'b0;
      end else begin
         if (pl_en) begin
            e_tv[0][16]  <= 1'b1;
            e_tag[0][16] <= '0;
            for (int k = 0; k < CLS; k++) e_dat[0][16][k] <= mem_f(32'h40 + k);
         end
         for (int w = 0; w < NW; w++) begin
            if (tag_we_o[w]) begin
               e_tv[w][sram_index_o]  <= tag_wdata_o[31];
               e_tag[w][sram_index_o] <= tag_wdata_o[22:0];
               last_tag_way <= w;
            end
            if (data_we_o[w]) e_dat[w][sram_index_o][sram_word_o] <= data_wdata_o;
         end
      end
      if (tag_we_o != '0) begin
         tag_cnt       <= tag_cnt + 1;
         last_tag_word <= tag_wdata_o;
      end
      if (!$onehot0(tag_we_o) || !$onehot0(data_we_o) || (tag_we_o != '0 && data_we_o != '0))
         proto_err <= proto_err + 1;
   end

   // Memory responder state shared with the main sequence.
   int          fixed_w = 3;
   int          spur_en = 0;
   int          wcnt = 0, wtarget = 0, beat_exp = 0, w_total = 0, ack_cnt = 0, mreq_cyc = 0;
   int          exp_victim = 0;
   logic [31:0] exp_base = '0;

   function automatic int pick_wait();
      return (fixed_w >= 0) ? fixed_w : int'($urandom_range(0, 3));
   endfunction

   initial begin
      logic [NW-1:0] ev;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            mem_ack_i = 1'b0;
         end else if (mem_req_o) begin
            mreq_cyc++;
            if (wcnt >= wtarget) begin
               mem_ack_i  = 1'b1;
               mem_data_i = mem_f(mem_addr_o);
               w_total   += wtarget;
               ev = '0;
               ev[exp_victim] = 1'b1;
               #1;
               check("beat_addr", 64'(mem_addr_o), 64'(exp_base + 32'(beat_exp)));
               check("beat_word", 64'(sram_word_o), 64'(beat_exp));
               check("beat_we",   64'(data_we_o), 64'(ev));
               check("beat_data", 64'(data_wdata_o), 64'(mem_f(exp_base + 32'(beat_exp))));
               beat_exp++;
               ack_cnt++;
               wcnt    = 0;
               wtarget = pick_wait();
            end else begin
               mem_ack_i = 1'b0;
               wcnt++;
            end
         end else if (spur_en == 1 || (spur_en == 2 && $urandom_range(0, 2) == 0)) begin
            mem_ack_i  = 1'b1;
            mem_data_i = $urandom;
            #1;
            check("spur_we", 64'(data_we_o), 64'(0));
         end else begin
            mem_ack_i = 1'b0;
         end
      end
   end

   // Reference model: which line each way holds per index, plus the replacement pointer.
   bit          m_valid [NW][NIDX];
   logic [22:0] m_tag   [NW][NIDX];
   int          m_rr = 0;
   int          bp_err = 0;

   task automatic do_read(input logic [31:0] addr, input bit hold, input logic [31:0] next_addr);
      int          idx, hit_way, k, t0;
      bit          got;
      logic [22:0] tg;
      idx = int'((addr >> 2) & 32'h7F);
      tg  = addr[31:9];
      hit_way = -1;
      for (int w = 0; w < NW; w++)
         if (m_valid[w][idx] && m_tag[w][idx] == tg) hit_way = w;
      req_valid_i = 1'b1;
      req_addr_i  = addr;
      exp_victim  = m_rr;
      exp_base    = addr & ~32'h3;
      beat_exp = 0; w_total = 0; ack_cnt = 0; mreq_cyc = 0; wcnt = 0;
      wtarget  = pick_wait();
      t0       = tag_cnt;
      #1;
      check("ready_idle", 64'(req_ready_o), 64'(1));
      check("sram_re",    64'(sram_re_o), 64'(1));
      check("sram_index", 64'(sram_index_o), 64'(idx));
      @(posedge clk);
      #1;
      if (hold) req_addr_i = next_addr;
      else      req_valid_i = 1'b0;
      k = 0; got = 0;
      while (k < 200 && !got) begin
         @(negedge clk);
         k++;
         if (resp_valid_o) got = 1;
         else if (hold && req_ready_o) bp_err++;
      end
      check("resp_seen", 64'(got), 64'(1));
      if (hit_way >= 0) begin
         check("hit_latency", 64'(k), 64'(2));
         check("hit_no_mem",  64'(mreq_cyc), 64'(0));
         check("hit_no_tag",  64'(tag_cnt), 64'(t0));
      end else begin
         check("miss_latency", 64'(k), 64'(4 + 2 * CLS + w_total));
         check("miss_beats",   64'(ack_cnt), 64'(CLS));
         check("miss_tagwr",   64'(tag_cnt), 64'(t0 + 1));
         check("miss_tagway",  64'(last_tag_way), 64'(m_rr));
         check("miss_tagword", 64'(last_tag_word), 64'(32'h8000_0000 | 32'(tg)));
         m_valid[m_rr][idx] = 1'b1;
         m_tag[m_rr][idx]   = tg;
         m_rr = (m_rr + 1) % NW;
      end
      check("resp_data", 64'(resp_data_o), 64'(mem_f(addr)));
      @(negedge clk);
      check("resp_1cyc", 64'(resp_valid_o), 64'(0));
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_i = 1'b1;
      req_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      m_rr = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, rst_addr;
      int          k, t0;
      int          rr_exp [3];
      rr_exp = '{0, 1, 0};
      for (int w = 0; w < NW; w++)
         for (int i = 0; i < NIDX; i++) m_valid[w][i] = 1'b0;

      env_clr = 1'b1;
      rst_i   = 1'b1;
      repeat (3) @(negedge clk);
      env_clr = 1'b0;
      check("rst_ready",  64'(req_ready_o), 64'(1));
      check("rst_resp",   64'(resp_valid_o), 64'(0));
      check("rst_rdata",  64'(resp_data_o), 64'(0));
      check("rst_memreq", 64'(mem_req_o), 64'(0));
      check("rst_sramre", 64'(sram_re_o), 64'(0));
      check("rst_tagwe",  64'(tag_we_o), 64'(0));
      check("rst_datawe", 64'(data_we_o), 64'(0));
      rst_i = 1'b0;
      @(negedge clk);

      // Preloaded hit on 0x40
      pl_en = 1'b1;
      @(negedge clk);
      pl_en = 1'b0;
      m_valid[0][16] = 1'b1;
      m_tag[0][16]   = '0;
      do_read(32'h40, 1'b0, 32'h0);
      check("hit_deadbeef", 64'(resp_data_o), 64'(32'hDEAD_BEEF));

      // Cold miss with three wait states per beat
      fixed_w = 3;
      do_read(32'h1234, 1'b0, 32'h0);

      // Reset after the second beat of a fill
      rst_addr = (32'd5 << 9) | (32'd100 << 2) | 32'd1;
      req_valid_i = 1'b1;
      req_addr_i  = rst_addr;
      exp_victim  = m_rr;
      exp_base    = rst_addr & ~32'h3;
      beat_exp = 0; w_total = 0; ack_cnt = 0; wcnt = 0; wtarget = pick_wait();
      t0 = tag_cnt;
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      k = 0;
      while (k < 200 && beat_exp < 2) begin
         @(negedge clk);
         k++;
      end
      check("rst_fill_beat2", 64'(beat_exp >= 2), 64'(1));
      @(negedge clk);
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_memreq", 64'(mem_req_o), 64'(0));
      check("midrst_resp",   64'(resp_valid_o), 64'(0));
      check("midrst_sramre", 64'(sram_re_o), 64'(0));
      check("midrst_tagwe",  64'(tag_we_o), 64'(0));
      check("midrst_datawe", 64'(data_we_o), 64'(0));
      @(negedge clk);
      rst_i = 1'b0;
      m_rr  = 0;
      check("midrst_notag", 64'(tag_cnt), 64'(t0));
      do_read(rst_addr, 1'b0, 32'h0);

      // Round robin over one index
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         do_read((32'(i + 1) << 9) | (32'd50 << 2), 1'b0, 32'h0);
         check("rr_victim", 64'(last_tag_way), 64'(rr_exp[i]));
      end

      // Back-pressure: request held through a fill, second one accepted from IDLE
      fixed_w = 1;
      bp_err  = 0;
      do_read((32'd7 << 9) | (32'd70 << 2), 1'b1, (32'd8 << 9) | (32'd71 << 2) | 32'd2);
      check("bp_ready_low", 64'(bp_err), 64'(0));
      do_read((32'd8 << 9) | (32'd71 << 2) | 32'd2, 1'b0, 32'h0);

      // Spurious acks in every gap cycle
      spur_en = 1;
      do_read((32'd9 << 9) | (32'd80 << 2) | 32'd3, 1'b0, 32'h0);

      // Random traffic over a few indices and tags
      spur_en = 2;
      fixed_w = -1;
      for (int n = 0; n < 40; n++) begin
         a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 2) |
             32'($urandom_range(0, 3));
         do_read(a, 1'b0, 32'h0);
      end

      check("protocol_onehot", 64'(proto_err), 64'(0));
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
